// File: rtl/gift_pt_packer.sv
// gift_pt_packer: packs an MSB-first byte stream into 64-bit GIFT plaintext blocks behind a 2-entry buffer; `define GIFT_PAD_EN adds ISO/IEC 7816-4 padding
module gift_pt_packer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [63:0]      blk_data,
    output logic             blk_last,
    output logic [CNT_W-1:0] blk_count
);
    logic [2:0]  idx;
    logic [55:0] asm_q;
    logic [63:0] head, tail, nb, push_data;
    logic        head_last, tail_last, push_last;
    logic [1:0]  occ;
    logic        acc, pop, push, full, fin;

    assign full      = occ == 2'd2;
    assign acc       = in_valid && in_ready;
    assign pop       = blk_valid && blk_ready;
    assign blk_valid = occ != 2'd0;
    assign blk_data  = head;
    assign blk_last  = head_last;

`ifdef GIFT_PAD_EN
    logic pad_pend;
    // a last byte completes the block early, so it stalls on a full buffer just like idx 7
    assign in_ready  = !pad_pend && !(full && (idx == 3'd7 || in_last));
    assign fin       = acc && (idx == 3'd7 || in_last);
    assign push      = fin || (pad_pend && !full);
    assign push_data = pad_pend ? 64'h8000_0000_0000_0000 : nb;
    assign push_last = pad_pend || (in_last && idx != 3'd7);

    // a message ending exactly on a block boundary needs a whole extra pad block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pad_pend <= 1'b0;
        else if (fin && in_last && idx == 3'd7)
            pad_pend <= 1'b1;
        else if (pad_pend && !full)
            pad_pend <= 1'b0;
    end
`else
    // ready only drops when the completing byte has nowhere to go
    assign in_ready  = !(full && idx == 3'd7);
    assign fin       = acc && idx == 3'd7;
    assign push      = fin;
    assign push_data = nb;
    assign push_last = 1'b0;
`endif

    // completed block: stored bytes, the current byte, then 0x80 and zero fill after it
    always_comb begin
        nb = '0;
        for (int j = 0; j < 8; j++)
            nb[63-8*j -: 8] = j < int'(idx) ? asm_q[55-8*j -: 8] :
                              j == int'(idx) ? in_data :
                              j == int'(idx) + 1 ? 8'h80 : 8'h00;
    end

    // byte index and assembly register; byte 7 goes straight into the pushed block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= 3'd0;
            asm_q <= '0;
        end else if (acc) begin
            idx <= fin ? 3'd0 : idx + 3'd1;
            if (idx != 3'd7)
                asm_q[55-8*idx -: 8] <= in_data;
        end
    end

    // two-entry shift buffer with the head held in its own register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            head_last <= 1'b0;
            tail_last <= 1'b0;
            occ       <= 2'd0;
            blk_count <= '0;
        end else begin
            if (push && pop) begin
                if (full) begin
                    head      <= tail;
                    head_last <= tail_last;
                    tail      <= push_data;
                    tail_last <= push_last;
                end else begin
                    head      <= push_data;
                    head_last <= push_last;
                end
            end else if (push) begin
                if (occ == 2'd0) begin
                    head      <= push_data;
                    head_last <= push_last;
                end else begin
                    tail      <= push_data;
                    tail_last <= push_last;
                end
                occ <= occ + 2'd1;
            end else if (pop) begin
                head      <= tail;
                head_last <= tail_last;
                occ       <= occ - 2'd1;
            end
            if (pop)
                blk_count <= blk_count + 1'b1;
        end
    end
endmodule
